// File: rtl/robs_pkg.sv
// robs_pkg -- shared types, constants and helpers for the robs_divider
// signed sequential divider.
//   div_state_t : divider FSM states (IDLE, ITER, FIX, DONE)
//   ABS_W       : working width of the abs_u helper (operands must be < ABS_W bits)
//   DBZ_QUOT    : quotient pattern reported on divide by zero (all ones)
//   abs_u()     : unsigned magnitude of a sign-extended two's-complement value
package robs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int ABS_W = 64;

  // Callers truncate this to their own operand width.
  localparam logic [ABS_W-1:0] DBZ_QUOT = '1;

  // Magnitude of a signed value. The most-negative value maps to 2^(n-1),
  // which still fits once the caller truncates back to its unsigned width.
  function automatic logic [ABS_W-1:0] abs_u(input logic signed [ABS_W-1:0] v);
    return v[ABS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_addsub.sv
// div_addsub -- (WIDTH+1)-bit add/subtract of the partial remainder and the
// zero-extended divisor magnitude. Purely combinational.
//   p   : partial remainder, two's complement, WIDTH+1 bits
//   m   : divisor magnitude, unsigned, WIDTH bits
//   sub : 1 -> p - m, 0 -> p + m
//   res : result, WIDTH+1 bits
module div_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] m,
  input  logic             sub,
  output logic [WIDTH:0]   res
);

  logic [WIDTH:0] m_ext;

  assign m_ext = {1'b0, m};
  assign res   = sub ? (p - m_ext) : (p + m_ext);

endmodule

// File: rtl/robs_divider.sv
// robs_divider -- signed sequential integer divider (truncating toward zero).
// Non-restoring shift-subtract on operand magnitudes, then a sign-fix step.
// The remainder carries the dividend's sign and |remainder| < |divisor|.
//
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset, clears all state/outputs
//   start       : request, sampled only while idle
//   dividend    : signed dividend, captured at the start edge
//   divisor     : signed divisor, captured at the start edge
//   busy        : high from the start edge until done drops
//   done        : one-cycle pulse, results valid from this cycle
//   quotient    : signed quotient (held until the next result)
//   remainder   : signed remainder (held until the next result)
//   div_by_zero : set with done when the divisor was 0
//   ovf         : (only with ROBS_DIV_SAT_EN) pulsed with done when
//                 most-negative / -1 was saturated
//
// Build option: define ROBS_DIV_SAT_EN to saturate most-negative / -1 to the
// most-positive quotient and add the ovf port. Without it the quotient wraps
// to the most-negative value.
module robs_divider
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef ROBS_DIV_SAT_EN
  output logic             ovf,
`endif
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;          // partial remainder, signed
  logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude -> quotient magnitude
  logic [WIDTH-1:0] m_q, m_d;          // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_dvd_q, neg_dvd_d;
  logic             neg_dvs_q, neg_dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
`ifdef ROBS_DIV_SAT_EN
  logic             ovf_q, ovf_d;
`endif

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   as_p;
  logic             as_sub;
  logic [WIDTH:0]   as_res;
  logic [WIDTH:0]   p_fix;

  // Upper half of {P,Q} << 1.
  assign p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};

  // The single adder serves both the iteration step and the final restore.
  always_comb begin
    as_p   = p_shift;
    as_sub = ~p_q[WIDTH];
    if (state_q == FIX) begin
      as_p   = p_q;
      as_sub = 1'b0;
    end
  end

  div_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .p   (as_p),
    .m   (m_q),
    .sub (as_sub),
    .res (as_res)
  );

  // A negative final partial remainder needs one add-back of M.
  assign p_fix = p_q[WIDTH] ? as_res : p_q;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
`ifdef ROBS_DIV_SAT_EN
    ovf_d     = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d       = WIDTH'(abs_u(ABS_W'(signed'(dividend))));
          m_d       = WIDTH'(abs_u(ABS_W'(signed'(divisor))));
          p_d       = '0;
          neg_dvd_d = dividend[WIDTH-1];
          neg_dvs_d = divisor[WIDTH-1];
          cnt_d     = CNT_W'(WIDTH);
          dbz_d     = 1'b0;
          state_d   = (divisor == '0) ? FIX : ITER;
        end
      end

      ITER: begin
        p_d   = as_res;
        q_d   = {q_q[WIDTH-2:0], ~as_res[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = DONE;
        if (m_q == '0) begin
          // Q still holds |dividend|; re-applying the sign returns the
          // original dividend, including the most-negative value.
          quot_d = WIDTH'(DBZ_QUOT);
          rem_d  = neg_dvd_q ? -q_q : q_q;
          dbz_d  = 1'b1;
        end else begin
          p_d    = p_fix;
          quot_d = (neg_dvd_q ^ neg_dvs_q) ? -q_q : q_q;
          rem_d  = neg_dvd_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
`ifdef ROBS_DIV_SAT_EN
          // A same-sign quotient with the top magnitude bit set can only be
          // most-negative / -1.
          if (!(neg_dvd_q ^ neg_dvs_q) && q_q[WIDTH-1]) begin
            quot_d = {1'b0, {(WIDTH-1){1'b1}}};
            ovf_d  = 1'b1;
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
`ifdef ROBS_DIV_SAT_EN
        ovf_d   = 1'b0;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      p_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
`ifdef ROBS_DIV_SAT_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
`ifdef ROBS_DIV_SAT_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
`ifdef ROBS_DIV_SAT_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_robs_divider.sv
// tb_robs_divider -- directed self-checking bench for robs_divider (WIDTH=8).
// Define ROBS_DIV_SAT_EN for both bench and design to exercise saturation.
module tb_robs_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
`ifdef ROBS_DIV_SAT_EN
  logic       ovf;
`endif

  int n_checks;
  int n_fail;

  robs_divider #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
`ifdef ROBS_DIV_SAT_EN
    .ovf         (ovf),
`endif
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation starting in the current (idle) cycle and return in
  // the cycle where done is seen. Cycle 1 is the cycle after the start edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int dcyc, output int busy_low);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    dcyc     = -1;
    busy_low = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (!busy) busy_low++;
      if (done) begin
        dcyc = k;
        break;
      end
    end
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b done_cycle=%0d",
             $signed(a), $signed(b), $signed(quotient), $signed(remainder),
             div_by_zero, dcyc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #3;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b dbz=%0b q=%h r=%h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int dc, bl;
    run_op(8'd100, 8'd7, dc, bl);
    n_checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_100_7: got q=%h r=%h dbz=%0b, want 0e 02 0",
               quotient, remainder, div_by_zero);
    end
    n_checks++;
    if (dc !== 10) begin
      n_fail++;
      $display("FAIL basic_latency: got done cycle %0d, want 10", dc);
    end
    n_checks++;
    if (bl !== 0) begin
      n_fail++;
      $display("FAIL basic_busy: got %0d cycles with busy low, want 0", bl);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd14) begin
      n_fail++;
      $display("FAIL basic_after_done: got done=%0b busy=%0b q=%h, want 0 0 0e",
               done, busy, quotient);
    end
  endtask

  task automatic test_signs();
    logic [7:0] a_tab [6] = '{8'h9C, 8'd100, 8'h9C, 8'd5, 8'd7,  8'h80};
    logic [7:0] b_tab [6] = '{8'd7,  8'hF9,  8'hF9, 8'd9, 8'd7,  8'd1};
    logic [7:0] q_tab [6] = '{8'hF2, 8'hF2,  8'd14, 8'd0, 8'd1,  8'h80};
    logic [7:0] r_tab [6] = '{8'hFE, 8'd2,   8'hFE, 8'd5, 8'd0,  8'd0};
    int dc, bl;
    for (int i = 0; i < 6; i++) begin
      run_op(a_tab[i], b_tab[i], dc, bl);
      n_checks++;
      if (quotient !== q_tab[i] || remainder !== r_tab[i] || dc !== 10) begin
        n_fail++;
        $display("FAIL signs_%0d: got q=%h r=%h cycle=%0d, want q=%h r=%h cycle=10",
                 i, quotient, remainder, dc, q_tab[i], r_tab[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    int dc, bl;
    run_op(8'd42, 8'd0, dc, bl);
    n_checks++;
    if (quotient !== 8'hFF || remainder !== 8'd42 || div_by_zero !== 1'b1 || dc !== 2) begin
      n_fail++;
      $display("FAIL dbz_42: got q=%h r=%h dbz=%0b cycle=%0d, want ff 2a 1 2",
               quotient, remainder, div_by_zero, dc);
    end
`ifdef ROBS_DIV_SAT_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_ovf: got ovf=%0b, want 0", ovf);
    end
`endif
    @(posedge clk);
    #1;
    run_op(8'h80, 8'd0, dc, bl);
    n_checks++;
    if (quotient !== 8'hFF || remainder !== 8'h80 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_min: got q=%h r=%h dbz=%0b, want ff 80 1",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    int dc, bl;
    run_op(8'h80, 8'hFF, dc, bl);
`ifdef ROBS_DIV_SAT_EN
    n_checks++;
    if (quotient !== 8'h7F || remainder !== 8'd0 || ovf !== 1'b1 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_sat: got q=%h r=%h ovf=%0b dbz=%0b, want 7f 00 1 0",
               quotient, remainder, ovf, div_by_zero);
    end
`else
    n_checks++;
    if (quotient !== 8'h80 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_wrap: got q=%h r=%h dbz=%0b, want 80 00 0",
               quotient, remainder, div_by_zero);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int dc, bl;
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dc = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (k == 4) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
      end else if (k == 5) begin
        start = 1'b0;
      end
      if (done) begin
        dc = k;
        break;
      end
    end
    $display("op 100 / 7 with ignored 9/3 -> q=%0d r=%0d done_cycle=%0d",
             $signed(quotient), $signed(remainder), dc);
    n_checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || dc !== 10) begin
      n_fail++;
      $display("FAIL ignore_start: got q=%h r=%h cycle=%0d, want 0e 02 10",
               quotient, remainder, dc);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_not_queued: got busy=%0b, want 0", busy);
    end
    run_op(8'd9, 8'd3, dc, bl);
    n_checks++;
    if (quotient !== 8'd3 || remainder !== 8'd0 || dc !== 10) begin
      n_fail++;
      $display("FAIL back_to_back: got q=%h r=%h cycle=%0d, want 03 00 10",
               quotient, remainder, dc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int dc, bl, seen;
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%0b done=%0b dbz=%0b q=%h r=%h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d cycles with done/busy high, want 0", seen);
    end
    run_op(8'd127, 8'h80, dc, bl);
    n_checks++;
    if (quotient !== 8'd0 || remainder !== 8'd127 || dc !== 10) begin
      n_fail++;
      $display("FAIL after_reset_127: got q=%h r=%h cycle=%0d, want 00 7f 10",
               quotient, remainder, dc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
